// File: rtl/hex7seg_pkg.sv
// Shared constants for the hex 7-segment scan driver: segment bit positions,
// the active-high glyph table and the scanner state type.
package hex7seg_pkg;

    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    // Bits 6:0 = g f e d c b a, active-high.
    localparam logic [6:0] GLYPHS [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } state_t;

    function automatic int clog2_min1(input int v);
        return (v <= 1) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/hex7seg_glyph.sv
// Combinational hex nibble to active-high 7-segment pattern (g..a).
module hex7seg_glyph
    import hex7seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] pattern
);

    assign pattern = GLYPHS[nibble];

endmodule

// File: rtl/hex7seg_scan_driver.sv
// Time-multiplexed multi-digit hex display driver with tear-free frame updates.
// Optional HEX7SEG_LEADING_ZERO_BLANK_EN blanks segments of leading-zero digits.
module hex7seg_scan_driver
    import hex7seg_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int DIGIT_CYCLES   = 50000,
    parameter int BLANK_CYCLES   = 500,
    parameter int SEG_ACTIVE_LOW = 0,
    parameter int DIG_ACTIVE_LOW = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp,
    output logic [7:0]              seg,
    output logic [NUM_DIGITS-1:0]   digit_sel,
    output logic                    frame_done
);

    localparam int MAX_CYC = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
    localparam int CNT_W   = clog2_min1(MAX_CYC);
    localparam int IDX_W   = clog2_min1(NUM_DIGITS);

    localparam logic [CNT_W-1:0]      BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0]      DIGIT_LAST = CNT_W'(DIGIT_CYCLES - 1);
    localparam logic [IDX_W-1:0]      IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [7:0]            SEG_INV    = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
    localparam logic [NUM_DIGITS-1:0] DIG_INV    = (DIG_ACTIVE_LOW != 0) ? '1 : '0;

    state_t                    state_q, state_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [4*NUM_DIGITS-1:0]   shadow_val_q, shadow_val_d;
    logic [NUM_DIGITS-1:0]     shadow_dp_q, shadow_dp_d;
    logic [4*NUM_DIGITS-1:0]   pend_val_q, pend_val_d;
    logic [NUM_DIGITS-1:0]     pend_dp_q, pend_dp_d;
    logic                      pend_flag_q, pend_flag_d;
    logic [7:0]                seg_q, seg_d;
    logic [NUM_DIGITS-1:0]     digit_sel_q, digit_sel_d;
    logic                      frame_done_q, frame_done_d;

    logic                      wrap;
    logic [3:0]                nib;
    logic                      dp_bit;
    logic [6:0]                pattern;
    logic                      lz_blank;
    logic [7:0]                seg_raw;
    logic [NUM_DIGITS-1:0]     dig_raw;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= BLANK;
            idx_q        <= '0;
            cnt_q        <= '0;
            shadow_val_q <= '0;
            shadow_dp_q  <= '0;
            pend_val_q   <= '0;
            pend_dp_q    <= '0;
            pend_flag_q  <= 1'b0;
            seg_q        <= SEG_INV;
            digit_sel_q  <= DIG_INV;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            shadow_val_q <= shadow_val_d;
            shadow_dp_q  <= shadow_dp_d;
            pend_val_q   <= pend_val_d;
            pend_dp_q    <= pend_dp_d;
            pend_flag_q  <= pend_flag_d;
            seg_q        <= seg_d;
            digit_sel_q  <= digit_sel_d;
            frame_done_q <= frame_done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        wrap    = 1'b0;
        if (!enable) begin
            state_d = BLANK;
            idx_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                BLANK: begin
                    if (cnt_q == BLANK_LAST) begin
                        state_d = SHOW;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                SHOW: begin
                    if (cnt_q == DIGIT_LAST) begin
                        state_d = BLANK;
                        cnt_d   = '0;
                        if (idx_q == IDX_LAST) begin
                            idx_d = '0;
                            wrap  = 1'b1;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = BLANK;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Shadow only changes at a frame boundary or while the scanner is parked,
    // so a frame is always drawn from one consistent value.
    always_comb begin
        pend_val_d   = pend_val_q;
        pend_dp_d    = pend_dp_q;
        pend_flag_d  = pend_flag_q;
        shadow_val_d = shadow_val_q;
        shadow_dp_d  = shadow_dp_q;
        if (load) begin
            pend_val_d  = value;
            pend_dp_d   = dp;
            pend_flag_d = 1'b1;
        end
        if (!enable || wrap) begin
            if (load) begin
                shadow_val_d = value;
                shadow_dp_d  = dp;
            end else if (pend_flag_q) begin
                shadow_val_d = pend_val_q;
                shadow_dp_d  = pend_dp_q;
            end
            pend_flag_d = 1'b0;
        end
    end

    always_comb begin
        nib    = 4'h0;
        dp_bit = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx_d == IDX_W'(k)) begin
                nib    = shadow_val_d[4*k +: 4];
                dp_bit = shadow_dp_d[k];
            end
        end
    end

    hex7seg_glyph u_glyph (
        .nibble  (nib),
        .pattern (pattern)
    );

`ifdef HEX7SEG_LEADING_ZERO_BLANK_EN
    logic [IDX_W-1:0] msd;

    // Digit 0 stays lit when everything is zero because msd defaults to 0.
    always_comb begin
        msd = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (shadow_val_d[4*k +: 4] != 4'h0) begin
                msd = IDX_W'(k);
            end
        end
    end

    assign lz_blank = (idx_d > msd);
`else
    assign lz_blank = 1'b0;
`endif

    always_comb begin
        seg_raw = 8'h00;
        dig_raw = '0;
        if (state_d == SHOW) begin
            seg_raw[SEG_G:SEG_A] = lz_blank ? 7'h00 : pattern;
            seg_raw[SEG_DP]      = dp_bit;
            dig_raw              = NUM_DIGITS'(1) << idx_d;
        end
        seg_d        = seg_raw ^ SEG_INV;
        digit_sel_d  = dig_raw ^ DIG_INV;
        frame_done_d = wrap;
    end

    assign seg        = seg_q;
    assign digit_sel  = digit_sel_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_hex7seg_scan_driver.sv
// Directed bench for hex7seg_scan_driver: 4 digits, 4-cycle digits, 1-cycle blank,
// with an active-high and an active-low instance sharing the same stimulus.
module tb_hex7seg_scan_driver;

    logic        clk = 1'b0;
    logic        reset, enable, load;
    logic [15:0] value;
    logic [3:0]  dp;
    logic [7:0]  seg, segn;
    logic [3:0]  dig, dign;
    logic        fd, fdn;

    int checks = 0;
    int errors = 0;

    localparam logic [6:0] TBL [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    logic [7:0] cap_seg  [20];
    logic [7:0] cap_segn [20];
    logic [3:0] cap_dig  [20];
    logic [3:0] cap_dign [20];
    logic       cap_fd   [20];

    always #5 clk = ~clk;

    hex7seg_scan_driver #(
        .NUM_DIGITS(4), .DIGIT_CYCLES(4), .BLANK_CYCLES(1),
        .SEG_ACTIVE_LOW(0), .DIG_ACTIVE_LOW(0)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .load(load),
        .value(value), .dp(dp), .seg(seg), .digit_sel(dig), .frame_done(fd)
    );

    hex7seg_scan_driver #(
        .NUM_DIGITS(4), .DIGIT_CYCLES(4), .BLANK_CYCLES(1),
        .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(1)
    ) dut_n (
        .clk(clk), .reset(reset), .enable(enable), .load(load),
        .value(value), .dp(dp), .seg(segn), .digit_sel(dign), .frame_done(fdn)
    );

    // Expected active-high seg for frame position i (0..19 after a frame_done cycle).
    function automatic logic [7:0] exp_seg(input logic [15:0] v, input logic [3:0] d, input int i);
        int g;
        int msd;
        logic [7:0] s;
        g = i / 5;
        if ((i % 5) == 4) return 8'h00;
        s = {d[g], TBL[v[4*g +: 4]]};
`ifdef HEX7SEG_LEADING_ZERO_BLANK_EN
        msd = 0;
        for (int k = 0; k < 4; k++) if (v[4*k +: 4] != 4'h0) msd = k;
        if (g > msd) s[6:0] = 7'h00;
`else
        msd = 0;
`endif
        return s;
    endfunction

    function automatic logic [3:0] exp_dig(input int i);
        if ((i % 5) == 4) return 4'h0;
        return 4'b0001 << (i / 5);
    endfunction

    // Records the 20 cycles following a frame_done cycle; optionally pulses load at cycle ld_at.
    task automatic capture(input int ld_at, input logic [15:0] lv, input logic [3:0] ld);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            @(negedge clk);
            cap_seg[i]  = seg;
            cap_segn[i] = segn;
            cap_dig[i]  = dig;
            cap_dign[i] = dign;
            cap_fd[i]   = fd;
            if (i + 1 == ld_at) begin
                load = 1'b1; value = lv; dp = ld;
            end else begin
                load = 1'b0;
            end
        end
    endtask

    task automatic test_reset;
        int first;
        reset = 1'b1; enable = 1'b1; load = 1'b0; value = 16'h0; dp = 4'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({seg, dig, fd} !== {8'h00, 4'h0, 1'b0}) begin
            errors++;
            $display("FAIL reset_outputs seg=%h dig=%b fd=%b, want 00 0000 0", seg, dig, fd);
        end
        checks++;
        if ({segn, dign} !== {8'hFF, 4'hF}) begin
            errors++;
            $display("FAIL reset_outputs_lo seg=%h dig=%b, want ff 1111", segn, dign);
        end
        reset = 1'b0;
        first = 0;
        for (int n = 1; n <= 30; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (n == 1) begin
                checks++;
                if ({seg, dig} !== {8'h3F, 4'b0001}) begin
                    errors++;
                    $display("FAIL first_show seg=%h dig=%b, want 3f 0001", seg, dig);
                end
                checks++;
                if ({segn, dign} !== {8'hC0, 4'b1110}) begin
                    errors++;
                    $display("FAIL first_show_lo seg=%h dig=%b, want c0 1110", segn, dign);
                end
            end
            if (fd === 1'b1) begin
                first = n;
                break;
            end
        end
        checks++;
        if (first != 20) begin
            errors++;
            $display("FAIL first_frame_done at cycle %0d, want 20", first);
        end
    endtask

    task automatic test_load_mid_frame;
        capture(5, 16'h1A3F, 4'b0100);
        for (int i = 0; i < 20; i++) begin
            checks++;
            if ({cap_seg[i], cap_dig[i], cap_fd[i], cap_segn[i], cap_dign[i]} !==
                {exp_seg(16'h0, 4'h0, i), exp_dig(i), i == 19, ~exp_seg(16'h0, 4'h0, i), ~exp_dig(i)}) begin
                errors++;
                $display("FAIL old_shadow cyc %0d got seg=%h dig=%b fd=%b, want seg=%h dig=%b",
                         i, cap_seg[i], cap_dig[i], cap_fd[i], exp_seg(16'h0, 4'h0, i), exp_dig(i));
            end
        end
        capture(-1, 16'h0, 4'h0);
        for (int i = 0; i < 20; i++) begin
            checks++;
            if ({cap_seg[i], cap_dig[i], cap_fd[i], cap_segn[i], cap_dign[i]} !==
                {exp_seg(16'h1A3F, 4'b0100, i), exp_dig(i), i == 19, ~exp_seg(16'h1A3F, 4'b0100, i), ~exp_dig(i)}) begin
                errors++;
                $display("FAIL new_shadow cyc %0d got seg=%h dig=%b fd=%b, want seg=%h dig=%b",
                         i, cap_seg[i], cap_dig[i], cap_fd[i], exp_seg(16'h1A3F, 4'b0100, i), exp_dig(i));
            end
        end
    endtask

    task automatic test_back_to_back;
        load = 1'b1; value = 16'h0001; dp = 4'h0;
        capture(2, 16'h0002, 4'h0);
        for (int i = 0; i < 20; i++) begin
            checks++;
            if ({cap_seg[i], cap_dig[i], cap_fd[i]} !== {exp_seg(16'h1A3F, 4'b0100, i), exp_dig(i), i == 19}) begin
                errors++;
                $display("FAIL b2b_hold cyc %0d got seg=%h dig=%b, want seg=%h dig=%b",
                         i, cap_seg[i], cap_dig[i], exp_seg(16'h1A3F, 4'b0100, i), exp_dig(i));
            end
        end
        capture(-1, 16'h0, 4'h0);
        for (int i = 0; i < 20; i++) begin
            checks++;
            if ({cap_seg[i], cap_dig[i], cap_fd[i]} !== {exp_seg(16'h0002, 4'h0, i), exp_dig(i), i == 19}) begin
                errors++;
                $display("FAIL b2b_last_wins cyc %0d got seg=%h dig=%b, want seg=%h dig=%b",
                         i, cap_seg[i], cap_dig[i], exp_seg(16'h0002, 4'h0, i), exp_dig(i));
            end
        end
    endtask

    task automatic test_glyph_sweep;
        logic [15:0] prev;
        prev = 16'h0002;
        for (int n = 0; n <= 16; n++) begin
            if (n < 16) begin
                load = 1'b1; value = 16'(n); dp = 4'h0;
            end
            capture(-1, 16'h0, 4'h0);
            for (int i = 0; i < 20; i++) begin
                checks++;
                if ({cap_seg[i], cap_dig[i], cap_fd[i], cap_segn[i], cap_dign[i]} !==
                    {exp_seg(prev, 4'h0, i), exp_dig(i), i == 19, ~exp_seg(prev, 4'h0, i), ~exp_dig(i)}) begin
                    errors++;
                    $display("FAIL sweep val=%h cyc %0d got seg=%h dig=%b fd=%b, want seg=%h dig=%b",
                             prev, i, cap_seg[i], cap_dig[i], cap_fd[i], exp_seg(prev, 4'h0, i), exp_dig(i));
                end
            end
            prev = 16'(n);
        end
    endtask

    task automatic test_boundary_load;
        capture(19, 16'h5678, 4'b1001);
        capture(-1, 16'h0, 4'h0);
        for (int i = 0; i < 20; i++) begin
            checks++;
            if ({cap_seg[i], cap_dig[i], cap_fd[i]} !== {exp_seg(16'h5678, 4'b1001, i), exp_dig(i), i == 19}) begin
                errors++;
                $display("FAIL boundary_load cyc %0d got seg=%h dig=%b, want seg=%h dig=%b",
                         i, cap_seg[i], cap_dig[i], exp_seg(16'h5678, 4'b1001, i), exp_dig(i));
            end
        end
    endtask

    task automatic test_enable;
        int first;
        repeat (11) begin
            @(posedge clk);
            @(negedge clk);
        end
        checks++;
        if (dig !== 4'b0100) begin
            errors++;
            $display("FAIL en_pre_digit2 dig=%b, want 0100", dig);
        end
        enable = 1'b0; load = 1'b1; value = 16'h00E0; dp = 4'h0;
        for (int n = 0; n < 7; n++) begin
            @(posedge clk);
            @(negedge clk);
            load = 1'b0;
            checks++;
            if ({seg, dig, fd, segn, dign} !== {8'h00, 4'h0, 1'b0, 8'hFF, 4'hF}) begin
                errors++;
                $display("FAIL disabled cyc %0d seg=%h dig=%b fd=%b, want 00 0000 0", n, seg, dig, fd);
            end
        end
        enable = 1'b1;
        first = 0;
        for (int n = 1; n <= 25; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (n == 1) begin
                checks++;
                if ({seg, dig} !== {8'h3F, 4'b0001}) begin
                    errors++;
                    $display("FAIL restart_digit0 seg=%h dig=%b, want 3f 0001", seg, dig);
                end
            end
            if (n == 6) begin
                checks++;
                if ({seg, dig} !== {8'h79, 4'b0010}) begin
                    errors++;
                    $display("FAIL disabled_load_digit1 seg=%h dig=%b, want 79 0010", seg, dig);
                end
            end
            if (fd === 1'b1) begin
                first = n;
                break;
            end
        end
        checks++;
        if (first != 20) begin
            errors++;
            $display("FAIL restart_frame_done at cycle %0d, want 20", first);
        end
    endtask

`ifdef HEX7SEG_LEADING_ZERO_BLANK_EN
    task automatic test_leading_zero;
        load = 1'b1; value = 16'h0040; dp = 4'h0;
        capture(-1, 16'h0, 4'h0);
        capture(-1, 16'h0, 4'h0);
        checks++;
        if ({cap_seg[0], cap_seg[5], cap_seg[10], cap_seg[15]} !== {8'h3F, 8'h66, 8'h00, 8'h00}) begin
            errors++;
            $display("FAIL lzb_0040 seg d0..d3=%h %h %h %h, want 3f 66 00 00",
                     cap_seg[0], cap_seg[5], cap_seg[10], cap_seg[15]);
        end
        checks++;
        if ({cap_dig[10], cap_dig[15]} !== {4'b0100, 4'b1000}) begin
            errors++;
            $display("FAIL lzb_digit_sel d2=%b d3=%b, want 0100 1000", cap_dig[10], cap_dig[15]);
        end
        load = 1'b1; value = 16'h0000; dp = 4'h0;
        capture(-1, 16'h0, 4'h0);
        capture(-1, 16'h0, 4'h0);
        checks++;
        if ({cap_seg[0], cap_seg[5], cap_seg[10], cap_seg[15]} !== {8'h3F, 8'h00, 8'h00, 8'h00}) begin
            errors++;
            $display("FAIL lzb_0000 seg d0..d3=%h %h %h %h, want 3f 00 00 00",
                     cap_seg[0], cap_seg[5], cap_seg[10], cap_seg[15]);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_load_mid_frame();
        test_back_to_back();
        test_glyph_sweep();
        test_boundary_load();
        test_enable();
`ifdef HEX7SEG_LEADING_ZERO_BLANK_EN
        test_leading_zero();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
